// File: rtl/ahb_bm_dma_phy_addr_decoder_if.sv
// Bus-side signals of one bus-matrix master port: the master's address
// phase, the per-region slave responses, and the muxed response back.
interface ahb_bm_dma_phy_addr_decoder_if;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [3:0]   HSEL_S;
    logic         HSEL_DEF;
    logic [3:0]   HREADYOUT_S;
    logic [7:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         HREADYOUT_D;
    logic [1:0]   HRESP_D;
    logic         HREADY_M;
    logic [1:0]   HRESP_M;
    logic [31:0]  HRDATA_M;

    // Environment side: drives address phase and slave responses.
    modport master (
        output HADDR, HTRANS, HREADY,
        output HREADYOUT_S, HRESP_S, HRDATA_S, HREADYOUT_D, HRESP_D,
        input  HSEL_S, HSEL_DEF, HREADY_M, HRESP_M, HRDATA_M
    );

    // Decoder side.
    modport slave (
        input  HADDR, HTRANS, HREADY,
        input  HREADYOUT_S, HRESP_S, HRDATA_S, HREADYOUT_D, HRESP_D,
        output HSEL_S, HSEL_DEF, HREADY_M, HRESP_M, HRDATA_M
    );
endinterface

// File: rtl/ahb_bm_dma_phy_addr_decoder.sv
// Address decoder + response mux for one DMA/PHY bus-matrix master port.
// Four mask/base regions (lowest index wins on overlap) plus a default
// slave; a saturating counter tracks transfers that hit the default slave.
module ahb_bm_dma_phy_addr_decoder #(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] BASE1 = 32'h2000_0000,
    parameter logic [31:0] BASE2 = 32'h4000_0000,
    parameter logic [31:0] BASE3 = 32'h5000_0000,
    parameter logic [31:0] MASK0 = 32'hE000_0000,
    parameter logic [31:0] MASK1 = 32'hE000_0000,
    parameter logic [31:0] MASK2 = 32'hF000_0000,
    parameter logic [31:0] MASK3 = 32'hF000_0000
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    ahb_bm_dma_phy_addr_decoder_if.slave    bus,
    input  logic                            dec_err_clr,
    output logic [7:0]                      dec_err_cnt
);
    localparam int          NUM_REG = 4;
    localparam logic [2:0]  SEL_DEF = 3'd4;

    logic [NUM_REG-1:0][31:0] base_v;
    logic [NUM_REG-1:0][31:0] mask_v;
    logic [NUM_REG-1:0]       hit;
    logic [2:0]               dec_idx;
    logic [2:0]               sel_q;
    logic                     err_inc;

    assign base_v = {BASE3, BASE2, BASE1, BASE0};
    assign mask_v = {MASK3, MASK2, MASK1, MASK0};

    genvar n;
    generate
        for (n = 0; n < NUM_REG; n++) begin : g_hit
            assign hit[n] = (bus.HADDR & mask_v[n]) == base_v[n];
        end
    endgenerate

    // Priority encode the hits; scanning downward leaves the lowest index.
    always_comb begin
        dec_idx = SEL_DEF;
        for (int i = NUM_REG - 1; i >= 0; i--)
            if (hit[i]) dec_idx = 3'(i);
    end

    // One-hot address-phase selects; HTRANS qualification is the slave's job.
    always_comb begin
        bus.HSEL_S   = '0;
        bus.HSEL_DEF = 1'b0;
        if (dec_idx[2]) bus.HSEL_DEF = 1'b1;
        else            bus.HSEL_S[dec_idx[1:0]] = 1'b1;
    end

    // Data-phase select: advances only when the previous data phase ends,
    // so wait states and the first ERROR cycle freeze routing.
    always_ff @(posedge HCLK) begin
        if (HRESET)          sel_q <= SEL_DEF;
        else if (bus.HREADY) sel_q <= dec_idx;
    end

    // Response mux; unreachable codes 5-7 fall back to the default slave.
    always_comb begin
        if (sel_q[2]) begin
            bus.HREADY_M = bus.HREADYOUT_D;
            bus.HRESP_M  = bus.HRESP_D;
            bus.HRDATA_M = 32'h0;
        end else begin
            bus.HREADY_M = bus.HREADYOUT_S[sel_q[1:0]];
            bus.HRESP_M  = bus.HRESP_S[{sel_q[1:0], 1'b0} +: 2];
            bus.HRDATA_M = bus.HRDATA_S[{sel_q[1:0], 5'b0} +: 32];
        end
    end

    assign err_inc = bus.HREADY & bus.HTRANS[1] & bus.HSEL_DEF;

    // Decode-error counter: clear beats increment, saturates at 0xFF.
    always_ff @(posedge HCLK) begin
        if (HRESET)                          dec_err_cnt <= 8'h00;
        else if (dec_err_clr)                dec_err_cnt <= 8'h00;
        else if (err_inc && dec_err_cnt != 8'hFF) dec_err_cnt <= dec_err_cnt + 8'h01;
    end
endmodule
